// File: rtl/smg_tick_gen.sv
// Clock-enable timing generator for the smg display scan and DS18B20 sample fetch, all in clk_50MHz.
// Define SMG_TICK_SQUARE_EN to add the legacy 50% square outputs scan_clk / slow_clk.
module smg_tick_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int SLOW_DIV = 1_000,
    parameter int DIGITS   = 8,
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ,
    localparam int DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    input  logic          en,
    input  logic          sclr,
    output logic          scan_tick,
    output logic [DW-1:0] digit_idx,
    output logic          slow_tick,
    output logic          rd_strobe
`ifdef SMG_TICK_SQUARE_EN
    ,
    output logic          scan_clk,
    output logic          slow_clk
`endif
);

    localparam int C1W = $clog2(SCAN_DIV);
    localparam int C2W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [C1W-1:0] C1_TC = C1W'(SCAN_DIV - 1);
    localparam logic [C2W-1:0] C2_TC = C2W'(SLOW_DIV - 1);
    localparam logic [DW-1:0]  D_TC  = DW'(DIGITS - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("smg_tick_gen: SCAN_DIV = CLK_HZ/SCAN_HZ must be >= 2");
    end
    if (CLK_HZ % SCAN_HZ != 0) begin : g_bad_scan_ratio
        $error("smg_tick_gen: CLK_HZ must be an integer multiple of SCAN_HZ");
    end
    if (SLOW_DIV < 1) begin : g_bad_slow_div
        $error("smg_tick_gen: SLOW_DIV must be >= 1");
    end
    if (DIGITS < 1) begin : g_bad_digits
        $error("smg_tick_gen: DIGITS must be >= 1");
    end

    logic [C1W-1:0] cnt1_q, cnt1_d;
    logic [C2W-1:0] cnt2_q, cnt2_d;
    logic [DW-1:0]  digit_q, digit_d;
    logic           scan_tick_q, scan_tick_d;
    logic           slow_tick_q, slow_tick_d;
    logic           rd_strobe_q, rd_strobe_d;
    logic           scan_ev, slow_ev;

    always_comb begin
        scan_ev     = en && (cnt1_q == C1_TC);
        slow_ev     = scan_ev && (cnt2_q == C2_TC);
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        digit_d     = digit_q;
        scan_tick_d = scan_ev;
        slow_tick_d = slow_ev;
        // The read strobe trails slow_tick regardless of en so a fetch is never half-issued.
        rd_strobe_d = slow_tick_q;
        if (en) begin
            cnt1_d = scan_ev ? '0 : cnt1_q + 1'b1;
        end
        if (scan_ev) begin
            cnt2_d  = slow_ev ? '0 : cnt2_q + 1'b1;
            digit_d = (digit_q == D_TC) ? '0 : digit_q + 1'b1;
        end
        if (sclr) begin
            cnt1_d      = '0;
            cnt2_d      = '0;
            digit_d     = '0;
            scan_tick_d = 1'b0;
            slow_tick_d = 1'b0;
            rd_strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            digit_q     <= '0;
            scan_tick_q <= 1'b0;
            slow_tick_q <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            digit_q     <= digit_d;
            scan_tick_q <= scan_tick_d;
            slow_tick_q <= slow_tick_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    assign scan_tick = scan_tick_q;
    assign digit_idx = digit_q;
    assign slow_tick = slow_tick_q;
    assign rd_strobe = rd_strobe_q;

`ifdef SMG_TICK_SQUARE_EN
    if (SCAN_DIV % 2 != 0) begin : g_odd_scan_div
        $error("smg_tick_gen: square outputs need an even SCAN_DIV");
    end
    if (SLOW_DIV > 1 && SLOW_DIV % 2 != 0) begin : g_odd_slow_div
        $error("smg_tick_gen: square outputs need an even SLOW_DIV");
    end

    localparam logic [C1W-1:0] C1_HALF = C1W'(SCAN_DIV / 2 - 1);
    localparam logic [C2W-1:0] C2_HALF = C2W'(SLOW_DIV / 2 - 1);

    logic scan_clk_q, scan_clk_d;
    logic slow_clk_q, slow_clk_d;

    // Toggle points at the half and terminal counts give exact 50% duty for even divisors.
    always_comb begin
        scan_clk_d = scan_clk_q;
        slow_clk_d = slow_clk_q;
        if (en && (cnt1_q == C1_HALF || cnt1_q == C1_TC)) begin
            scan_clk_d = ~scan_clk_q;
        end
        if (scan_ev && (SLOW_DIV == 1 || cnt2_q == C2_HALF || cnt2_q == C2_TC)) begin
            slow_clk_d = ~slow_clk_q;
        end
        if (sclr) begin
            scan_clk_d = 1'b0;
            slow_clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            scan_clk_q <= 1'b0;
            slow_clk_q <= 1'b0;
        end else begin
            scan_clk_q <= scan_clk_d;
            slow_clk_q <= slow_clk_d;
        end
    end

    assign scan_clk = scan_clk_q;
    assign slow_clk = slow_clk_q;
`endif

endmodule

// File: tb/tb_smg_tick_gen.sv
// Directed bench for smg_tick_gen: small divisors for cycle-exact checks, plus a 2 s run at a scaled clock.
module tb_smg_tick_gen;

    logic       clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    logic       rst = 1'b0, en = 1'b0, sclr = 1'b0;
    logic       scan_tick, slow_tick, rd_strobe;
    logic [1:0] digit_idx;

    logic       rst2 = 1'b0, en2 = 1'b0, sclr2 = 1'b0;
    logic       scan_tick2, slow_tick2, rd_strobe2;
    logic [2:0] digit_idx2;

`ifdef SMG_TICK_SQUARE_EN
    logic scan_clk, slow_clk, scan_clk2, slow_clk2;
`endif

    int n_err = 0;
    int n_chk = 0;

    smg_tick_gen #(.CLK_HZ(100), .SCAN_HZ(10), .SLOW_DIV(4), .DIGITS(3)) u_dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .en        (en),
        .sclr      (sclr),
        .scan_tick (scan_tick),
        .digit_idx (digit_idx),
        .slow_tick (slow_tick),
        .rd_strobe (rd_strobe)
`ifdef SMG_TICK_SQUARE_EN
        ,
        .scan_clk  (scan_clk),
        .slow_clk  (slow_clk)
`endif
    );

    // Scaled stand-in for the default build: SCAN_DIV=2, SLOW_DIV=1000, 2000 clocks per second.
    smg_tick_gen #(.CLK_HZ(2000), .SCAN_HZ(1000), .SLOW_DIV(1000), .DIGITS(8)) u_def (
        .clk_50MHz (clk_50MHz),
        .rst       (rst2),
        .en        (en2),
        .sclr      (sclr2),
        .scan_tick (scan_tick2),
        .digit_idx (digit_idx2),
        .slow_tick (slow_tick2),
        .rd_strobe (rd_strobe2)
`ifdef SMG_TICK_SQUARE_EN
        ,
        .scan_clk  (scan_clk2),
        .slow_clk  (slow_clk2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_main(input string p, input int c, input int s, input int d,
                            input int sl, input int rd, input int sc, input int sw);
        check($sformatf("%s scan_tick c%0d", p, c), 32'(scan_tick), s);
        check($sformatf("%s digit_idx c%0d", p, c), 32'(digit_idx), d);
        check($sformatf("%s slow_tick c%0d", p, c), 32'(slow_tick), sl);
        check($sformatf("%s rd_strobe c%0d", p, c), 32'(rd_strobe), rd);
`ifdef SMG_TICK_SQUARE_EN
        check($sformatf("%s scan_clk c%0d", p, c), 32'(scan_clk), sc);
        check($sformatf("%s slow_clk c%0d", p, c), 32'(slow_clk), sw);
`endif
    endtask

    // Leaves the bench mid-way through cycle 0: reset just released with en=1.
    task automatic restart();
        rst  = 1'b0;
        en   = 1'b0;
        sclr = 1'b0;
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b1;
        en  = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk_50MHz);
        #1;
    endtask

    initial begin
        int e, s_cnt, sl_cnt, rd_cnt, wide, order;
        logic p_scan, p_slow, p_rd;

        // Reset state
        repeat (3) @(posedge clk_50MHz);
        #1;
        chk_main("reset", 0, 0, 0, 0, 0, 0, 0);

        // Free-running count
        restart();
        for (int c = 0; c <= 45; c++) begin
            if (c > 0) next_cycle();
            chk_main("run", c, int'(c > 0 && c % 10 == 0), (c / 10) % 3,
                     int'(c == 40), int'(c == 41), (c / 5) % 2, (c / 20) % 2);
        end

        // en low during cycles 5..11: counters freeze at cnt1=5
        restart();
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) next_cycle();
            e = (c <= 5) ? c : ((c <= 12) ? 5 : c - 7);
            chk_main("freeze", c, int'(c == 17 || c == 27), (e / 10) % 3, 0, 0,
                     (e / 5) % 2, (e / 20) % 2);
            en = !(c >= 5 && c <= 11);
        end

        // sclr on the edge a slow_tick is due, then again while slow_tick is high
        restart();
        for (int c = 0; c <= 95; c++) begin
            if (c > 0) next_cycle();
            if (c < 40)
                chk_main("sclr", c, int'(c > 0 && c % 10 == 0), (c / 10) % 3, 0, 0,
                         (c / 5) % 2, (c / 20) % 2);
            else if (c <= 80)
                chk_main("sclr", c, int'(c >= 50 && c % 10 == 0), ((c - 40) / 10) % 3,
                         int'(c == 80), 0, ((c - 40) / 5) % 2, ((c - 40) / 20) % 2);
            else
                chk_main("sclr", c, int'(c == 91), int'(c >= 91), 0, 0,
                         ((c - 81) / 5) % 2, 0);
            sclr = (c == 39 || c == 80);
        end

        // Asynchronous reset mid-count
        restart();
        repeat (23) next_cycle();
        check("async pre digit", 32'(digit_idx), 2);
        #2 rst = 1'b0;
        #1;
        chk_main("async", 23, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            chk_main("after_rst", c, int'(c == 10), int'(c >= 10), 0, 0, (c / 5) % 2, 0);
        end

        // Two simulated seconds on the scaled default divider chain
        @(negedge clk_50MHz);
        rst2 = 1'b1;
        en2  = 1'b1;
        s_cnt = 0; sl_cnt = 0; rd_cnt = 0; wide = 0; order = 0;
        p_scan = 1'b0; p_slow = 1'b0; p_rd = 1'b0;
        for (int c = 1; c <= 4001; c++) begin
            next_cycle();
            s_cnt  += int'(scan_tick2);
            sl_cnt += int'(slow_tick2);
            rd_cnt += int'(rd_strobe2);
            if ((scan_tick2 && p_scan) || (slow_tick2 && p_slow) || (rd_strobe2 && p_rd)) wide++;
            if (rd_strobe2 !== p_slow) order++;
            if (c == 6) check("2s digit c6", 32'(digit_idx2), 3);
            p_scan = scan_tick2;
            p_slow = slow_tick2;
            p_rd   = rd_strobe2;
        end
        check("2s scan_ticks", 32'(s_cnt), 2000);
        check("2s slow_ticks", 32'(sl_cnt), 2);
        check("2s rd_strobes", 32'(rd_cnt), 2);
        check("2s wide pulses", 32'(wide), 0);
        check("2s rd after slow", 32'(order), 0);
        check("2s final digit", 32'(digit_idx2), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
